// File: rtl/axi_node_pkg.sv
// axi_node_pkg
//   Shared definitions for the AXI node address decoder slice.
//   - state_t   : decoder FSM state encoding
//   - err_cnt_w : width needed to count 0..depth queued decode errors
package axi_node_pkg;

  typedef enum logic [0:0] {
    DECODE = 1'b0,
    HOLD   = 1'b1
  } state_t;

  function automatic int err_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axi_region_match.sv
// axi_region_match
//   Per-target address match vector from the region tables.
//   Ports:
//     addr          in  ADDR_WIDTH                          address under decode
//     start_addr    in  N_REGION x N_INIT_PORT x ADDR_WIDTH inclusive lower bounds
//     end_addr      in  N_REGION x N_INIT_PORT x ADDR_WIDTH inclusive upper bounds
//     enable_region in  N_REGION x N_INIT_PORT              region enables
//     match         out N_INIT_PORT                         target i hit by any enabled region
module axi_region_match #(
  parameter int ADDR_WIDTH  = 32,
  parameter int N_INIT_PORT = 8,
  parameter int N_REGION    = 2
) (
  input  logic [ADDR_WIDTH-1:0]                              addr,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] start_addr,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] end_addr,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0]                 enable_region,
  output logic [N_INIT_PORT-1:0]                               match
);

  always_comb begin
    match = '0;
    for (int i = 0; i < N_INIT_PORT; i++) begin
      for (int j = 0; j < N_REGION; j++) begin
        if (enable_region[j][i] &&
            (addr >= start_addr[j][i]) && (addr <= end_addr[j][i])) begin
          match[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi_address_decoder_ext.sv
// axi_address_decoder_ext
//   Routes an upstream address request to one of N_INIT_PORT targets, or
//   queues a decode error when nothing permitted matches.
//   State table:
//     DECODE | decode addr_i each cycle; forward, queue an error, or stall
//     HOLD   | forward latched target until its ready_i handshake
//   Ports:
//     clk, rst_n                  clock, synchronous active-low reset
//     valid_i, addr_i, ready_o    upstream request handshake
//     valid_o, ready_i            one-hot downstream handshake
//     START_ADDR_i, END_ADDR_i,
//     enable_region_i             region tables
//     connectivity_map_i          permitted targets
//     incr_req_o, full_counter_i,
//     outstanding_trans_i         outstanding-transaction counter interface
//     error_req_o, error_gnt_i,
//     sample_data_info_o          decode error response interface
//     multi_match_o               more than one permitted target hit
//     err_count_o                 queued error count
module axi_address_decoder_ext
  import axi_node_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int N_INIT_PORT  = 8,
  parameter int N_REGION     = 2,
  parameter int ERR_DEPTH    = 4,
  parameter bit DEFAULT_EN   = 1'b0,
  parameter int DEFAULT_PORT = 0
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               valid_i,
  input  logic [ADDR_WIDTH-1:0]                              addr_i,
  output logic                                               ready_o,
  output logic [N_INIT_PORT-1:0]                             valid_o,
  input  logic [N_INIT_PORT-1:0]                             ready_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] START_ADDR_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] END_ADDR_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0]                 enable_region_i,
  input  logic [N_INIT_PORT-1:0]                             connectivity_map_i,
  output logic                                               incr_req_o,
  input  logic                                               full_counter_i,
  input  logic                                               outstanding_trans_i,
  output logic                                               error_req_o,
  input  logic                                               error_gnt_i,
  output logic                                               sample_data_info_o,
  output logic                                               multi_match_o,
  output logic [err_cnt_w(ERR_DEPTH)-1:0]                    err_count_o
);

  localparam int                     CW      = err_cnt_w(ERR_DEPTH);
  localparam logic [CW-1:0]          ERR_MAX = CW'(ERR_DEPTH);
  localparam logic [N_INIT_PORT-1:0] DEF_OH  = N_INIT_PORT'(1) << DEFAULT_PORT;

  logic [N_INIT_PORT-1:0] region_hit;
  logic [N_INIT_PORT-1:0] match;
  logic [N_INIT_PORT-1:0] first_oh;
  logic [N_INIT_PORT-1:0] target_oh;
  logic                   multi;
  logic                   seen;
  logic                   routable;

  state_t                 state_q, state_d;
  logic [N_INIT_PORT-1:0] held_q, held_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [N_INIT_PORT-1:0] valid_w;
  logic                   ready_w, incr_w, sample_w, multi_w, err_req_w;
  logic                   accept, grant;

  axi_region_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .N_INIT_PORT(N_INIT_PORT),
    .N_REGION   (N_REGION)
  ) u_region_match (
    .addr         (addr_i),
    .start_addr   (START_ADDR_i),
    .end_addr     (END_ADDR_i),
    .enable_region(enable_region_i),
    .match        (region_hit)
  );

  assign match = region_hit & connectivity_map_i;

  // Downward scan so the lowest matching index is the last one written.
  always_comb begin
    first_oh = '0;
    multi    = 1'b0;
    seen     = 1'b0;
    for (int i = N_INIT_PORT - 1; i >= 0; i--) begin
      if (match[i]) first_oh = N_INIT_PORT'(1) << i;
    end
    for (int i = 0; i < N_INIT_PORT; i++) begin
      if (match[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
  end

  always_comb begin
    routable  = 1'b1;
    target_oh = first_oh;
    if (match == '0) begin
      if (DEFAULT_EN && connectivity_map_i[DEFAULT_PORT]) target_oh = DEF_OH;
      else                                                 routable  = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    valid_w   = '0;
    ready_w   = 1'b0;
    incr_w    = 1'b0;
    sample_w  = 1'b0;
    multi_w   = 1'b0;
    accept    = 1'b0;
    err_req_w = (cnt_q != '0) && !outstanding_trans_i;
    grant     = err_req_w && error_gnt_i;

    case (state_q)
      DECODE: begin
        if (valid_i) begin
          multi_w = multi;
          if (routable) begin
            // Queued errors must be answered before any later request goes out.
            if ((cnt_q == '0) && !full_counter_i) begin
              valid_w = target_oh;
              ready_w = |(ready_i & target_oh);
              incr_w  = ready_w;
              if (!ready_w) begin
                state_d = HOLD;
                held_d  = target_oh;
              end
            end
          end else if (cnt_q < ERR_MAX) begin
            ready_w  = 1'b1;
            sample_w = 1'b1;
            accept   = 1'b1;
          end
        end
      end
      HOLD: begin
        valid_w = held_q;
        ready_w = |(ready_i & held_q);
        incr_w  = ready_w;
        if (ready_w) state_d = DECODE;
      end
      default: state_d = DECODE;
    endcase

    // accept only below ERR_MAX and grant only above zero, so no wrap.
    case ({accept, grant})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DECODE;
      held_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low for the whole time reset is asserted.
  assign valid_o            = rst_n ? valid_w   : '0;
  assign ready_o            = rst_n && ready_w;
  assign incr_req_o         = rst_n && incr_w;
  assign sample_data_info_o = rst_n && sample_w;
  assign multi_match_o      = rst_n && multi_w;
  assign error_req_o        = rst_n && err_req_w;
  assign err_count_o        = rst_n ? cnt_q     : '0;

endmodule

// File: tb/tb_axi_address_decoder_ext.sv
module tb_axi_address_decoder_ext;

  localparam int AW = 32;
  localparam int NP = 8;
  localparam int NR = 2;
  localparam int ED = 4;
  localparam int CW = $clog2(ED + 1);
  localparam int DPORT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         rst_n;
  logic                         valid_i;
  logic [AW-1:0]                addr_i;
  logic [NP-1:0]                ready_i;
  logic [NR-1:0][NP-1:0][AW-1:0] start_a, end_a;
  logic [NR-1:0][NP-1:0]        en_r;
  logic [NP-1:0]                conn;
  logic                         full_i, outst_i, gnt_i;

  logic [NP-1:0] vo, vo_d;
  logic          ro, io, eo, so, mo;
  logic          ro_d, io_d, eo_d, so_d, mo_d;
  logic [CW-1:0] co, co_d;

  int vectors    = 0;
  int miscompares = 0;

  axi_address_decoder_ext #(
    .ADDR_WIDTH(AW), .N_INIT_PORT(NP), .N_REGION(NR), .ERR_DEPTH(ED),
    .DEFAULT_EN(1'b0), .DEFAULT_PORT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .addr_i(addr_i), .ready_o(ro),
    .valid_o(vo), .ready_i(ready_i), .START_ADDR_i(start_a), .END_ADDR_i(end_a),
    .enable_region_i(en_r), .connectivity_map_i(conn), .incr_req_o(io),
    .full_counter_i(full_i), .outstanding_trans_i(outst_i), .error_req_o(eo),
    .error_gnt_i(gnt_i), .sample_data_info_o(so), .multi_match_o(mo), .err_count_o(co)
  );

  axi_address_decoder_ext #(
    .ADDR_WIDTH(AW), .N_INIT_PORT(NP), .N_REGION(NR), .ERR_DEPTH(ED),
    .DEFAULT_EN(1'b1), .DEFAULT_PORT(DPORT)
  ) dut_def (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .addr_i(addr_i), .ready_o(ro_d),
    .valid_o(vo_d), .ready_i(ready_i), .START_ADDR_i(start_a), .END_ADDR_i(end_a),
    .enable_region_i(en_r), .connectivity_map_i(conn), .incr_req_o(io_d),
    .full_counter_i(full_i), .outstanding_trans_i(outst_i), .error_req_o(eo_d),
    .error_gnt_i(gnt_i), .sample_data_info_o(so_d), .multi_match_o(mo_d), .err_count_o(co_d)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // Pending request is routed to the lowest permitted matching port, else the
  // default port (if enabled), else it is an error. Errors form a bounded queue.
  task automatic model(input bit den, input int dport,
                       input bit hold, input int hidx, input int cnt,
                       output logic [NP-1:0] v, output bit r, output bit incr,
                       output bit ereq, output bit samp, output bit mm,
                       output int cnt_o,
                       output bit nhold, output int nhidx, output int ncnt);
    int first, nm, tgt;
    bit hit, acc, g;
    v = '0; r = 0; incr = 0; ereq = 0; samp = 0; mm = 0; cnt_o = 0;
    nhold = hold; nhidx = hidx; ncnt = cnt;
    if (!rst_n) begin
      nhold = 0; nhidx = 0; ncnt = 0;
      return;
    end
    first = -1; nm = 0;
    for (int i = 0; i < NP; i++) begin
      hit = 0;
      for (int j = 0; j < NR; j++)
        if (en_r[j][i] && addr_i >= start_a[j][i] && addr_i <= end_a[j][i]) hit = 1;
      if (hit && conn[i]) begin
        nm++;
        if (first < 0) first = i;
      end
    end
    if (first >= 0)               tgt = first;
    else if (den && conn[dport])  tgt = dport;
    else                          tgt = -1;
    cnt_o = cnt;
    ereq  = (cnt > 0) && !outst_i;
    g     = ereq && gnt_i;
    acc   = 0;
    if (hold) begin
      v = NP'(1) << hidx;
      r = ready_i[hidx];
      incr = r;
      nhold = !r;
    end else if (valid_i) begin
      mm = (nm > 1);
      if (tgt >= 0) begin
        if (cnt == 0 && !full_i) begin
          v = NP'(1) << tgt;
          r = ready_i[tgt];
          incr = r;
          nhold = !r;
          nhidx = tgt;
        end
      end else if (cnt < ED) begin
        r = 1; samp = 1; acc = 1;
      end
    end
    ncnt = cnt + int'(acc) - int'(g);
  endtask

  bit m1_hold = 0, m2_hold = 0, n1_hold = 0, n2_hold = 0;
  int m1_hidx = 0, m2_hidx = 0, n1_hidx = 0, n2_hidx = 0;
  int m1_cnt = 0, m2_cnt = 0, n1_cnt = 0, n2_cnt = 0;

  always @(negedge clk) begin
    logic [NP-1:0] ev;
    bit er, ei, ee, es, em;
    int ec;
    model(1'b0, 0, m1_hold, m1_hidx, m1_cnt, ev, er, ei, ee, es, em, ec,
          n1_hold, n1_hidx, n1_cnt);
    chk("m_valid", 32'(vo), 32'(ev));
    chk("m_ready", 32'(ro), 32'(er));
    chk("m_incr",  32'(io), 32'(ei));
    chk("m_ereq",  32'(eo), 32'(ee));
    chk("m_samp",  32'(so), 32'(es));
    chk("m_multi", 32'(mo), 32'(em));
    chk("m_count", 32'(co), 32'(ec));
    model(1'b1, DPORT, m2_hold, m2_hidx, m2_cnt, ev, er, ei, ee, es, em, ec,
          n2_hold, n2_hidx, n2_cnt);
    chk("md_valid", 32'(vo_d), 32'(ev));
    chk("md_ready", 32'(ro_d), 32'(er));
    chk("md_incr",  32'(io_d), 32'(ei));
    chk("md_ereq",  32'(eo_d), 32'(ee));
    chk("md_samp",  32'(so_d), 32'(es));
    chk("md_multi", 32'(mo_d), 32'(em));
    chk("md_count", 32'(co_d), 32'(ec));
  end

  always @(posedge clk) begin
    m1_hold <= n1_hold; m1_hidx <= n1_hidx; m1_cnt <= n1_cnt;
    m2_hold <= n2_hold; m2_hidx <= n2_hidx; m2_cnt <= n2_cnt;
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tables_port2();
    start_a = '0; end_a = '0; en_r = '0;
    start_a[0][2] = 32'h1000; end_a[0][2] = 32'h1FFF; en_r[0][2] = 1'b1;
  endtask

  task automatic rand_tables();
    for (int r = 0; r < NR; r++)
      for (int p = 0; p < NP; p++) begin
        start_a[r][p] = 32'($urandom_range(0, 32'hF000));
        end_a[r][p]   = start_a[r][p] + 32'($urandom_range(0, 32'h2000));
        en_r[r][p]    = ($urandom_range(0, 3) != 0);
      end
    conn = NP'($urandom) | NP'($urandom);
  endtask

  initial begin
    rst_n = 0; valid_i = 1; addr_i = 32'h1800; ready_i = '1;
    conn = '1; full_i = 0; outst_i = 0; gnt_i = 0;
    tables_port2();

    // reset holds all outputs low even with a routable request
    repeat (2) begin
      cyc();
      @(negedge clk);
      chk("rst_valid", 32'(vo), 32'h0);
      chk("rst_ready", 32'(ro), 32'h0);
      chk("rst_count", 32'(co), 32'h0);
    end

    // single match, zero-latency forward
    cyc(); rst_n = 1;
    @(negedge clk);
    chk("fwd_valid", 32'(vo), 32'h04);
    chk("fwd_ready", 32'(ro), 32'h1);
    chk("fwd_incr",  32'(io), 32'h1);
    chk("fwd_multi", 32'(mo), 32'h0);

    // ports 1 and 3 both match, port 1 not ready -> HOLD
    cyc();
    start_a[0][1] = 32'h2000; end_a[0][1] = 32'h2FFF; en_r[0][1] = 1'b1;
    start_a[1][3] = 32'h1F00; end_a[1][3] = 32'h20FF; en_r[1][3] = 1'b1;
    addr_i = 32'h2000; ready_i = 8'hFD;
    @(negedge clk);
    chk("mm_valid", 32'(vo), 32'h02);
    chk("mm_multi", 32'(mo), 32'h1);
    chk("mm_ready", 32'(ro), 32'h0);

    cyc(); addr_i = 32'h1800; en_r[0][1] = 1'b0;
    @(negedge clk);
    chk("hold1_valid", 32'(vo), 32'h02);
    chk("hold1_multi", 32'(mo), 32'h0);
    cyc(); addr_i = 32'h9999; full_i = 1; start_a[1][3] = 32'h0;
    @(negedge clk);
    chk("hold2_valid", 32'(vo), 32'h02);
    chk("hold2_ready", 32'(ro), 32'h0);
    cyc(); ready_i = '1;
    @(negedge clk);
    chk("hold3_valid", 32'(vo), 32'h02);
    chk("hold3_ready", 32'(ro), 32'h1);
    chk("hold3_incr",  32'(io), 32'h1);
    cyc(); valid_i = 0; full_i = 0;
    @(negedge clk);
    chk("hold_done", 32'(vo), 32'h0);

    // error queue fill with outstanding transactions
    cyc(); start_a = '0; end_a = '0; en_r = '0;
    valid_i = 1; addr_i = 32'h5000; outst_i = 1;
    for (int k = 0; k < ED; k++) begin
      if (k > 0) cyc();
      @(negedge clk);
      chk("eacc_ready", 32'(ro), 32'h1);
      chk("eacc_samp",  32'(so), 32'h1);
      chk("eacc_valid", 32'(vo), 32'h0);
      chk("eacc_count", 32'(co), 32'(k));
      chk("eacc_ereq",  32'(eo), 32'h0);
      if (k == 0) begin
        chk("def_valid", 32'(vo_d), 32'h20);
        chk("def_ereq",  32'(eo_d), 32'h0);
      end
    end
    cyc();
    @(negedge clk);
    chk("efull_count", 32'(co), 32'h4);
    chk("efull_ready", 32'(ro), 32'h0);
    chk("efull_samp",  32'(so), 32'h0);
    cyc(); tables_port2(); addr_i = 32'h1800;
    @(negedge clk);
    chk("eorder_valid", 32'(vo), 32'h0);
    chk("eorder_ready", 32'(ro), 32'h0);
    cyc(); start_a = '0; end_a = '0; en_r = '0; addr_i = 32'h5000; outst_i = 0;
    @(negedge clk);
    chk("ereq_on", 32'(eo), 32'h1);
    cyc(); gnt_i = 1;
    @(negedge clk);
    chk("egnt_ready", 32'(ro), 32'h0);
    cyc(); gnt_i = 0;
    @(negedge clk);
    chk("e5_count", 32'(co), 32'h3);
    chk("e5_ready", 32'(ro), 32'h1);
    chk("e5_samp",  32'(so), 32'h1);
    cyc(); valid_i = 0; outst_i = 1; gnt_i = 1;
    @(negedge clk);
    chk("e5_after", 32'(co), 32'h4);
    chk("gnt_ignored_ereq", 32'(eo), 32'h0);
    cyc();
    @(negedge clk);
    chk("gnt_ignored_cnt", 32'(co), 32'h4);
    cyc(); outst_i = 0;
    for (int k = ED; k > 0; k--) begin
      if (k < ED) cyc();
      @(negedge clk);
      chk("drain_count", 32'(co), 32'(k));
    end
    cyc(); gnt_i = 0;
    @(negedge clk);
    chk("drain_zero", 32'(co), 32'h0);
    chk("drain_ereq", 32'(eo), 32'h0);

    // full counter blocks, then reset mid-HOLD
    cyc(); tables_port2(); addr_i = 32'h1800; valid_i = 1; full_i = 1;
    @(negedge clk);
    chk("full_valid", 32'(vo), 32'h0);
    chk("full_ready", 32'(ro), 32'h0);
    cyc(); full_i = 0; ready_i = '0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(vo), 32'h04);
    cyc(); rst_n = 0;
    @(negedge clk);
    chk("mrst_valid", 32'(vo), 32'h0);
    chk("mrst_incr",  32'(io), 32'h0);
    cyc(); rst_n = 1; valid_i = 0;
    @(negedge clk);
    chk("post_rst_valid", 32'(vo), 32'h0);
    cyc(); valid_i = 1; ready_i = '1;
    @(negedge clk);
    chk("post_rst_fwd", 32'(vo), 32'h04);
    chk("post_rst_rdy", 32'(ro), 32'h1);

    // randomized traffic against the model
    rand_tables();
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst_n   = ($urandom_range(0, 299) != 0);
      valid_i = ($urandom_range(0, 3) != 0);
      addr_i  = 32'($urandom_range(0, 32'hFFFF));
      ready_i = NP'($urandom);
      full_i  = ($urandom_range(0, 7) == 0);
      outst_i = ($urandom_range(0, 3) == 0);
      gnt_i   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) rand_tables();
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_address_decoder_ext.md
AXI_ADDRESS_DECODER_EXT -- requirements
Module: axi_address_decoder_ext

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: address width.
REQ-002 SHALL have parameter N_INIT_PORT, default 8: number of target ports.
REQ-003 SHALL have parameter N_REGION, default 2: address regions per target.
REQ-004 SHALL have parameter ERR_DEPTH, default 4: maximum queued decode errors, at least 1.
REQ-005 SHALL have parameter DEFAULT_EN, default 0: when 1, unmatched addresses route to DEFAULT_PORT instead of error.
REQ-006 SHALL have parameter DEFAULT_PORT, default 0: fallback target index, less than N_INIT_PORT.
REQ-007 SHALL use one clock and a synchronous, active-low reset.
REQ-008 SHALL have these ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- valid_i  in  1  upstream address valid
- addr_i  in  ADDR_WIDTH  upstream address
- ready_o  out  1  upstream ready
- valid_o  out  N_INIT_PORT  one-hot per-target valid
- ready_i  in  N_INIT_PORT  per-target ready
- START_ADDR_i / END_ADDR_i  in  N_REGION x N_INIT_PORT x ADDR_WIDTH  inclusive region bounds
- enable_region_i  in  N_REGION x N_INIT_PORT  region enables
- connectivity_map_i  in  N_INIT_PORT  permitted targets
- incr_req_o  out  1  pulse on accepted forward handshake
- full_counter_i  in  1  outstanding counter full
- outstanding_trans_i  in  1  transactions still in flight
- error_req_o  out  1  request error response
- error_gnt_i  in  1  error response granted
- sample_data_info_o  out  1  pulse: capture ID/len of the errored request
- multi_match_o  out  1  pulse: more than one permitted target matched
- err_count_o  out  $clog2(ERR_DEPTH+1)  queued error count

Function
REQ-009 SHALL match target i when some enabled region j has START <= addr_i <= END (unsigned), masked by connectivity_map_i[i].
REQ-010 SHALL, on multiple matches, select the lowest index and assert multi_match_o for every cycle valid_i is high in DECODE with more than one match.
REQ-011 SHALL, with no match, select DEFAULT_PORT when DEFAULT_EN=1 and connectivity_map_i[DEFAULT_PORT]=1, otherwise classify the request as error.
REQ-012 SHALL implement FSM states DECODE and HOLD.
REQ-013 In DECODE with a routable request, err_count_o=0 and full_counter_i=0, SHALL drive the one-hot valid_o combinationally (zero latency), set ready_o=ready_i[target], and pulse incr_req_o on handshake.
REQ-014 SHALL move to HOLD when it drives valid_o and ready_i[target]=0, latching the one-hot target.
REQ-015 In HOLD SHALL drive the latched target regardless of addr_i or configuration changes, ignore full_counter_i, and return to DECODE on that target's ready_i.
REQ-016 SHALL hold valid_o=0 and ready_o=0 for a routable request while full_counter_i=1 or err_count_o>0 (errors stay ordered ahead of later requests).
REQ-017 SHALL accept an error request in DECODE when err_count_o<ERR_DEPTH: ready_o=1, sample_data_info_o=1, valid_o=0, err_count_o increments next cycle.
REQ-018 SHALL stall an error request (ready_o=0) when err_count_o=ERR_DEPTH.
REQ-019 SHALL assert error_req_o when err_count_o>0 and outstanding_trans_i=0, and decrement err_count_o on error_req_o and error_gnt_i.
REQ-020 SHALL leave err_count_o unchanged on a simultaneous error accept and error grant, and never wrap it.
REQ-021 SHALL ignore error_gnt_i when error_req_o=0.

Reset
REQ-022 SHALL, on rst_n=0 at a clock edge, enter DECODE with err_count_o=0 and cleared latched target; while rst_n=0, all outputs SHALL be 0.
REQ-023 SHALL drop a request held mid-HOLD on reset; the upstream re-presents it.

Structure
REQ-024 SHALL place the FSM state enum and the error-count width function in the shared axi_node package.
REQ-025 SHALL use one sub-module, axi_region_match, which computes the N_INIT_PORT match vector from the region tables and address.

Verification
REQ-026 Port 2 region 0x1000-0x1FFF, addr 0x1800, ready_i[2]=1 -> valid_o=0x04, ready_o=1, incr_req_o=1 in the same cycle.
REQ-027 Ports 1 and 3 both match 0x2000 -> valid_o=0x02, multi_match_o=1.
REQ-028 ready_i[1]=0 for 3 cycles while addr_i and the region tables change -> valid_o stays 0x02 until the handshake, then DECODE.
REQ-029 Five unmatched requests, ERR_DEPTH=4, outstanding_trans_i=1 -> four accepted with sample pulses, err_count_o=4, fifth stalled; drop outstanding_trans_i, grant one -> fifth accepted, count stays 4.
REQ-030 DEFAULT_EN=1, DEFAULT_PORT=5, unmatched address -> valid_o=0x20, error_req_o=0.
REQ-031 full_counter_i=1 with a routable request -> valid_o=0, ready_o=0; rst_n=0 mid-HOLD -> next cycle DECODE, all outputs 0.
